// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART TX scheduler: FSM state encoding
// and the default bit period (47.9 MHz core / 115200 baud).
package uart_tx_sched_pkg;

  localparam int CLKS_PER_BIT_DEF = 416;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte write port into the UART TX scheduler.
// Plain valid/ready; a byte transfers when both are high.
interface uart_tx_sched_if;

  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/uart_tx_sched_sync_fifo.sv
// Single-clock FIFO with registered level, async active-low reset.
// Head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic [AW:0]   level_nxt
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign do_push = push & (level_q != DEPTH);
  assign do_pop  = pop & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout      = mem[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/uart_tx_sched.sv
// UART TX scheduler: buffers bytes and serialises 8N1/8N2 frames,
// starting a new frame only while the peer hold input is low.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_AW      = 3,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk_core,
  input  logic             reset_n,
  uart_tx_sched_if.slave   wr,
  input  logic             hold,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] DEPTH =
    (FIFO_AW+1)'(1 << FIFO_AW);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            loaded_q, loaded_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            push, pop, can_pop, tick;
  logic [7:0]      head;
  logic [FIFO_AW:0] lvl_nxt;

  assign wr.wr_ready = (fifo_level != DEPTH);
  assign push    = wr.wr_valid & wr.wr_ready;
  assign can_pop = (fifo_level != '0) & ~hold;
  assign tick    = (cnt_q == CNT_MAX);

  sync_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk_core),
    .rst_n     (reset_n),
    .push      (push),
    .din       (wr.wr_data),
    .pop       (pop),
    .dout      (head),
    .level     (fifo_level),
    .level_nxt (lvl_nxt)
  );

  // A pop parks the byte in IDLE for one cycle (loaded_q), then START.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    loaded_d = loaded_q;
    pop      = 1'b0;
    if (state_q != ST_IDLE)
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (loaded_q) begin
          state_d  = ST_START;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end else if (can_pop) begin
          pop      = 1'b1;
          sh_d     = head;
          loaded_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            if (can_pop) begin
              pop      = 1'b1;
              sh_d     = head;
              loaded_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = sh_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE) | loaded_d
           | (lvl_nxt != '0);
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      loaded_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      loaded_q <= loaded_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: frame waveform table plus
// hold, full-FIFO, reset and two-stop-bit sequences.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       hold1 = 1'b0;
  logic       hold2 = 1'b0;
  logic       tx1, tx2, busy1, busy2;
  logic [2:0] lvl1, lvl2;
  int         tests = 0;
  int         fails = 0;

  uart_tx_sched_if wr1 ();
  uart_tx_sched_if wr2 ();

  uart_tx_sched #(
    .CLKS_PER_BIT (4),
    .FIFO_AW      (2),
    .STOP_BITS    (1)
  ) dut (
    .clk_core   (clk),
    .reset_n    (reset_n),
    .wr         (wr1),
    .hold       (hold1),
    .tx         (tx1),
    .busy       (busy1),
    .fifo_level (lvl1)
  );

  uart_tx_sched #(
    .CLKS_PER_BIT (4),
    .FIFO_AW      (2),
    .STOP_BITS    (2)
  ) dut2 (
    .clk_core   (clk),
    .reset_n    (reset_n),
    .wr         (wr2),
    .hold       (hold2),
    .tx         (tx2),
    .busy       (busy2),
    .fifo_level (lvl2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [0:9] frame;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic line(input int s);
    return (s == 2) ? tx2 : tx1;
  endfunction

  task automatic wait_fall(input int s, input int lim,
                           output int n);
    n = 0;
    while (line(s) === 1'b1 && n < lim) begin
      step();
      n++;
    end
  endtask

  // Entered on the first start-bit cycle; returns mid stop bit.
  task automatic rx_frame(input int s, input int hold_bit,
                          output logic [7:0] b);
    b = '0;
    step(2);
    chk("start_mid", 32'(line(s)), 0);
    for (int i = 0; i < 8; i++) begin
      step(4);
      b[i] = line(s);
      if (i == hold_bit) hold1 = 1'b1;
    end
    step(4);
    chk("stop_mid", 32'(line(s)), 1);
  endtask

  task automatic push1(input logic [7:0] d);
    wr1.wr_data  = d;
    wr1.wr_valid = 1'b1;
    step();
    wr1.wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [7:0] b;
    logic       exp_tx;
    int         highs;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h01, 10'b0100000001};
    vecs[2] = '{8'hC4, 10'b0001000111};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h00, 10'b0000000001};
    vecs[5] = '{8'h80, 10'b0000000011};

    wr1.wr_data = '0; wr1.wr_valid = 1'b0;
    wr2.wr_data = '0; wr2.wr_valid = 1'b0;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_tx", 32'(tx1), 1);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_level", 32'(lvl1), 0);
    chk("rst_ready", 32'(wr1.wr_ready), 1);
    chk("rst_tx2", 32'(tx2), 1);
    step(2);
    reset_n = 1'b1;
    step(2);

    // Frame waveform per byte, cycle by cycle from the push edge.
    for (int v = 0; v < 6; v++) begin
      push1(vecs[v].data);
      for (int k = 0; k <= 42; k++) begin
        if (k < 2 || k >= 42) exp_tx = 1'b1;
        else exp_tx = vecs[v].frame[(k-2)/4];
        chk("frame_tx", 32'(tx1), 32'(exp_tx));
        chk("frame_busy", 32'(busy1), 32'(k < 42));
        if (k < 42) step();
      end
      chk("frame_lvl", 32'(lvl1), 0);
    end

    // Fill under hold: fifth byte dropped.
    hold1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr1.wr_data  = 8'h10 + 8'(i);
      wr1.wr_valid = 1'b1;
      chk("fill_ready", 32'(wr1.wr_ready), 32'(i < 4));
      step();
    end
    wr1.wr_valid = 1'b0;
    chk("fill_lvl", 32'(lvl1), 4);
    chk("fill_busy", 32'(busy1), 1);
    step(5);
    chk("fill_tx_idle", 32'(tx1), 1);
    hold1 = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_fall(1, 100, n);
      chk("drain_gap", 32'(n), (f == 0) ? 2 : 3);
      chk("drain_lvl", 32'(lvl1), 32'(3 - f));
      rx_frame(1, -1, b);
      chk("drain_byte", 32'(b), 32'(8'h10 + 8'(f)));
    end
    step(1);
    chk("drain_busy_stop", 32'(busy1), 1);
    step(1);
    chk("drain_busy_end", 32'(busy1), 0);
    chk("drain_lvl_end", 32'(lvl1), 0);

    // Hold raised mid-frame: current frame finishes, next waits.
    hold1 = 1'b1;
    push1(8'h20); push1(8'h21); push1(8'h22);
    hold1 = 1'b0;
    wait_fall(1, 100, n);
    chk("hold_lat", 32'(n), 2);
    rx_frame(1, 2, b);
    chk("hold_byte0", 32'(b), 32'h20);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx1 === 1'b1) highs++;
    end
    chk("hold_idle", 32'(highs), 20);
    chk("hold_lvl", 32'(lvl1), 2);
    hold1 = 1'b0;
    wait_fall(1, 100, n);
    chk("hold_release", 32'(n), 2);
    rx_frame(1, -1, b);
    chk("hold_byte1", 32'(b), 32'h21);
    wait_fall(1, 100, n);
    chk("hold_gap", 32'(n), 3);
    rx_frame(1, -1, b);
    chk("hold_byte2", 32'(b), 32'h22);
    step(4);

    // Simultaneous push/pop, then full FIFO at stop end.
    hold1 = 1'b1;
    push1(8'h30); push1(8'h31); push1(8'h32);
    hold1 = 1'b0;
    wr1.wr_data = 8'h33; wr1.wr_valid = 1'b1;
    step();
    chk("pushpop_lvl", 32'(lvl1), 3);
    wr1.wr_data = 8'h34;
    step();
    wr1.wr_valid = 1'b0;
    chk("full_lvl", 32'(lvl1), 4);
    chk("full_fall", 32'(tx1), 0);
    rx_frame(1, -1, b);
    chk("full_byte0", 32'(b), 32'h30);
    step();
    wr1.wr_data = 8'h35; wr1.wr_valid = 1'b1;
    chk("full_ready", 32'(wr1.wr_ready), 0);
    step();
    wr1.wr_valid = 1'b0;
    chk("full_pop_lvl", 32'(lvl1), 3);
    chk("full_ready_after", 32'(wr1.wr_ready), 1);
    for (int f = 1; f < 5; f++) begin
      wait_fall(1, 100, n);
      chk("full_gap", 32'(n), (f == 1) ? 1 : 3);
      rx_frame(1, -1, b);
      chk("full_byte", 32'(b), 32'(8'h30 + 8'(f)));
    end
    wait_fall(1, 60, n);
    chk("full_no_extra", 32'(n), 60);
    chk("full_busy", 32'(busy1), 0);

    // Reset during data bit 3 with two bytes queued.
    hold1 = 1'b1;
    push1(8'h40); push1(8'h41); push1(8'h42);
    hold1 = 1'b0;
    wait_fall(1, 100, n);
    chk("rst_mid_lat", 32'(n), 2);
    step(18);
    chk("rst_mid_bit3", 32'(tx1), 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx1), 1);
    chk("rst_mid_lvl", 32'(lvl1), 0);
    chk("rst_mid_busy", 32'(busy1), 0);
    chk("rst_mid_ready", 32'(wr1.wr_ready), 1);
    step(3);
    reset_n = 1'b1;
    wait_fall(1, 100, n);
    chk("rst_no_frame", 32'(n), 100);
    chk("rst_busy_after", 32'(busy1), 0);

    // Two stop bits, back-to-back 0xFF then 0x00.
    wr2.wr_data = 8'hFF; wr2.wr_valid = 1'b1;
    step();
    wr2.wr_data = 8'h00;
    step();
    wr2.wr_valid = 1'b0;
    wait_fall(2, 10, n);
    chk("sb2_lat", 32'(n), 1);
    rx_frame(2, -1, b);
    chk("sb2_byte0", 32'(b), 32'hFF);
    wait_fall(2, 20, n);
    chk("sb2_gap", 32'(n), 7);
    rx_frame(2, -1, b);
    chk("sb2_byte1", 32'(b), 32'h00);
    step(5);
    chk("sb2_busy_stop", 32'(busy2), 1);
    chk("sb2_tx_stop", 32'(tx2), 1);
    step();
    chk("sb2_busy_end", 32'(busy2), 0);
    chk("sb2_lvl_end", 32'(lvl2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
